exp_acc_scheduler: RTL and testbench
====================================

Name: exp_acc_scheduler

Overview:
- Sequences block-floating-point accumulation of exponent-matched partial sums over a multi-group dot product.
- Sits downstream of the registered exponent-match stage and consumes one group max exponent per accepted beat.
- Tracks the running accumulator exponent, issues per-group alignment shifts to the accumulator and the incoming partial sum, and reports the final exponent.
- Counts groups per job and controls job start/finish with valid/ready handshakes.

Parameters:
- ACC_EXP_WIDTH, 6, width of group max exponent, accumulator exponent and shift outputs.
- MAX_GROUPS, 64, maximum groups per job; CNT_W = $clog2(MAX_GROUPS+1).
- SHIFT_MAX, 24, saturation limit of any alignment shift (accumulator mantissa width).

Ports:
- clk  in  1  clock
- reset  in  1  sync active-high reset
- start  in  1  job start pulse, sampled only in IDLE
- num_groups  in  CNT_W  groups in job, latched on accepted start
- in_valid  in  1  group max exponent valid
- in_ready  out  1  scheduler accepts group exponent
- in_max_exp  in  ACC_EXP_WIDTH  group max exponent
- align_valid  out  1  shift outputs valid (1-cycle pulse per accepted group)
- acc_clear  out  1  first group: load accumulator, do not add
- acc_shift  out  ACC_EXP_WIDTH  right-shift applied to accumulator
- psum_shift  out  ACC_EXP_WIDTH  right-shift applied to incoming partial sum
- acc_exp  out  ACC_EXP_WIDTH  current accumulator exponent
- out_valid  out  1  job result valid
- out_ready  in  1  consumer accepts result
- out_exp  out  ACC_EXP_WIDTH  final accumulator exponent
- busy  out  1  state != IDLE

Behaviour:
- Interface: reset reset, synchronous, active-high; clock clk.
- Reset: state=IDLE, group counter 0, and all outputs 0: in_ready, align_valid, acc_clear, acc_shift, psum_shift, acc_exp, out_valid, out_exp, busy. Reset mid-job aborts the job with no result.
- FSM states: IDLE, RUN, DONE.
- IDLE: on start=1, latch num_groups (0 treated as 1), clear counter, go to RUN next cycle. start in RUN or DONE is ignored.
- RUN: in_ready=1 (combinational from state). A beat is accepted when in_valid && in_ready.
  - First group: acc_exp <= in_max_exp, acc_clear=1, both shifts 0.
  - Later group, e = in_max_exp, a = acc_exp:
    - e > a: acc_shift = min(e-a, SHIFT_MAX), psum_shift=0, acc_exp <= e.
    - e <= a: acc_shift=0, psum_shift = min(a-e, SHIFT_MAX), acc_exp unchanged.
  - Subtraction is unsigned ACC_EXP_WIDTH; no wrap because the larger operand is always the minuend.
  - align_valid, acc_clear and both shifts are registered: they are asserted in the cycle after acceptance, for one cycle, then return to 0.
  - Counter increments per accepted beat. On acceptance of beat number num_groups, go to DONE.
- DONE: in_ready=0. out_valid=1 and out_exp=acc_exp from the cycle after the last align_valid. Hold until out_ready; on out_valid && out_ready go to IDLE next cycle and drop out_valid.
- If out_ready is already high on DONE entry, the handshake completes in one cycle.
- Back-to-back jobs: start may be asserted in the first IDLE cycle after DONE.
- acc_exp holds its value after the job until the next first-group load.

Optional Feature:
- Macro EXP_SCHED_SAT_CNT_EN.
- Defined: adds output sat_cnt [15:0]. It increments once per accepted beat whose raw shift exceeded SHIFT_MAX, saturates at 16'hFFFF, clears on accepted start, and resets to 0.
- Undefined: no port and no logic; shifts still saturate.

Decomposition:
- Package exp_sched_pkg holds: state_t enum {IDLE, RUN, DONE}, and default constants SHIFT_MAX and MAX_GROUPS.
- Sub-module exp_align_calc (combinational): inputs e, a, first. Outputs acc_shift, psum_shift, new_exp, sat flag.
- The top level holds the FSM, counter and output registers.

Test Plan:
- Single group: start, num_groups=1, in_max_exp=20 -> next cycle align_valid=1, acc_clear=1, shifts 0; then out_valid=1, out_exp=20.
- Growing exponent: num_groups=3, exps 10, 15, 15 -> acc_shift 0, 5, 0; psum_shift 0, 0, 0; out_exp=15.
- Shrinking plus saturation (SHIFT_MAX=24): exps 40, 5 -> second beat psum_shift=24, acc_exp=40; sat_cnt=1 when EXP_SCHED_SAT_CNT_EN is defined.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid and out_exp stable, in_ready=0, start ignored; out_ready=1 -> IDLE next cycle.
- Bubbles and num_groups=0: in_valid toggling 1, 0, 1 with num_groups=2 -> exactly two align_valid pulses; num_groups=0 -> job completes after 1 beat.
- Reset mid-RUN after 2 of 4 beats -> all outputs 0, state IDLE; a new start runs a full job with acc_clear on its first beat.

Source files
------------

// File: rtl/exp_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module : exp_sched_pkg
// Brief  : Shared types and default constants for the exponent scheduler.
// Rev    : 1.0
// ============================================================================
package exp_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int ACC_EXP_WIDTH_DEFAULT = 6;
  localparam int MAX_GROUPS_DEFAULT    = 64;
  localparam int SHIFT_MAX_DEFAULT     = 24;

endpackage
`default_nettype wire

// File: rtl/exp_align_calc.sv
`default_nettype none
// ============================================================================
// Module : exp_align_calc
// Brief  : Combinational alignment of a group exponent against the running
//          accumulator exponent; produces saturated shifts and the new exponent.
// Rev    : 1.0
// ============================================================================
module exp_align_calc
  import exp_sched_pkg::*;
#(
  parameter int ACC_EXP_WIDTH = ACC_EXP_WIDTH_DEFAULT,
  parameter int SHIFT_MAX     = SHIFT_MAX_DEFAULT
) (
  input  logic [ACC_EXP_WIDTH-1:0] e,
  input  logic [ACC_EXP_WIDTH-1:0] a,
  input  logic                     first,
  output logic [ACC_EXP_WIDTH-1:0] acc_shift,
  output logic [ACC_EXP_WIDTH-1:0] psum_shift,
  output logic [ACC_EXP_WIDTH-1:0] new_exp,
  output logic                     sat
);

  localparam logic [ACC_EXP_WIDTH-1:0] C_SHIFT_MAX = ACC_EXP_WIDTH'(SHIFT_MAX);

  logic                     w_grow;
  logic [ACC_EXP_WIDTH-1:0] w_diff;
  logic [ACC_EXP_WIDTH-1:0] w_shift;

  always_comb begin
    w_grow     = (e > a);
    // Larger operand is always the minuend, so the difference never wraps.
    w_diff     = w_grow ? (e - a) : (a - e);
    w_shift    = (w_diff > C_SHIFT_MAX) ? C_SHIFT_MAX : w_diff;
    acc_shift  = '0;
    psum_shift = '0;
    new_exp    = a;
    sat        = 1'b0;
    if (first) begin
      new_exp = e;
    end else begin
      sat = (w_diff > C_SHIFT_MAX);
      if (w_grow) begin
        acc_shift = w_shift;
        new_exp   = e;
      end else begin
        psum_shift = w_shift;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/exp_acc_scheduler.sv
`default_nettype none
// ============================================================================
// Module : exp_acc_scheduler
// Brief  : Block-floating-point accumulation sequencer: tracks the accumulator
//          exponent, issues per-group alignment shifts, reports final exponent.
//          Optional EXP_SCHED_SAT_CNT_EN adds a saturated-shift event counter.
// Rev    : 1.0
// ============================================================================
module exp_acc_scheduler
  import exp_sched_pkg::*;
#(
  parameter int ACC_EXP_WIDTH = ACC_EXP_WIDTH_DEFAULT,
  parameter int MAX_GROUPS    = MAX_GROUPS_DEFAULT,
  parameter int SHIFT_MAX     = SHIFT_MAX_DEFAULT,
  parameter int CNT_W         = $clog2(MAX_GROUPS + 1)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [CNT_W-1:0]         num_groups,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ACC_EXP_WIDTH-1:0] in_max_exp,
  output logic                     align_valid,
  output logic                     acc_clear,
  output logic [ACC_EXP_WIDTH-1:0] acc_shift,
  output logic [ACC_EXP_WIDTH-1:0] psum_shift,
  output logic [ACC_EXP_WIDTH-1:0] acc_exp,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ACC_EXP_WIDTH-1:0] out_exp,
  output logic                     busy
`ifdef EXP_SCHED_SAT_CNT_EN
  ,
  output logic [15:0]              sat_cnt
`endif
);

  state_t                   r_state;
  state_t                   w_state_next;
  logic [CNT_W-1:0]         r_num_groups;
  logic [CNT_W-1:0]         r_count;
  logic                     r_align_valid;
  logic                     r_acc_clear;
  logic [ACC_EXP_WIDTH-1:0] r_acc_shift;
  logic [ACC_EXP_WIDTH-1:0] r_psum_shift;
  logic [ACC_EXP_WIDTH-1:0] r_acc_exp;
  logic                     r_out_valid;
  logic [ACC_EXP_WIDTH-1:0] r_out_exp;

  logic                     w_start_acc;
  logic                     w_accept;
  logic                     w_first;
  logic                     w_last;
  logic                     w_out_hs;
  logic [ACC_EXP_WIDTH-1:0] w_calc_acc_shift;
  logic [ACC_EXP_WIDTH-1:0] w_calc_psum_shift;
  logic [ACC_EXP_WIDTH-1:0] w_calc_new_exp;
  logic                     w_sat;

  assign w_start_acc = (r_state == IDLE) && start;
  assign w_accept    = in_valid && in_ready;
  assign w_first     = (r_count == '0);
  assign w_last      = ((r_count + CNT_W'(1)) == r_num_groups);
  assign w_out_hs    = r_out_valid && out_ready;

  exp_align_calc #(
    .ACC_EXP_WIDTH (ACC_EXP_WIDTH),
    .SHIFT_MAX     (SHIFT_MAX)
  ) u_align_calc (
    .e          (in_max_exp),
    .a          (r_acc_exp),
    .first      (w_first),
    .acc_shift  (w_calc_acc_shift),
    .psum_shift (w_calc_psum_shift),
    .new_exp    (w_calc_new_exp),
    .sat        (w_sat)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (start) w_state_next = RUN;
      RUN:     if (w_accept && w_last) w_state_next = DONE;
      DONE:    if (w_out_hs) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready    = (r_state == RUN);
    busy        = (r_state != IDLE);
    align_valid = r_align_valid;
    acc_clear   = r_acc_clear;
    acc_shift   = r_acc_shift;
    psum_shift  = r_psum_shift;
    acc_exp     = r_acc_exp;
    out_valid   = r_out_valid;
    out_exp     = r_out_exp;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_num_groups  <= '0;
      r_count       <= '0;
      r_align_valid <= 1'b0;
      r_acc_clear   <= 1'b0;
      r_acc_shift   <= '0;
      r_psum_shift  <= '0;
      r_acc_exp     <= '0;
      r_out_valid   <= 1'b0;
      r_out_exp     <= '0;
    end else begin
      r_align_valid <= w_accept;
      r_acc_clear   <= w_accept && w_first;
      r_acc_shift   <= w_accept ? w_calc_acc_shift  : '0;
      r_psum_shift  <= w_accept ? w_calc_psum_shift : '0;
      if (w_accept) begin
        r_acc_exp <= w_calc_new_exp;
      end

      // A zero-length job is treated as a single group.
      if (w_start_acc) begin
        r_num_groups <= (num_groups == '0) ? CNT_W'(1) : num_groups;
        r_count      <= '0;
      end else if (w_accept) begin
        r_count <= r_count + CNT_W'(1);
      end

      // Result is presented one cycle after DONE entry, once the final
      // exponent has settled in the accumulator register.
      if (w_out_hs) begin
        r_out_valid <= 1'b0;
      end else if (r_state == DONE) begin
        r_out_valid <= 1'b1;
        r_out_exp   <= r_acc_exp;
      end
    end
  end

`ifdef EXP_SCHED_SAT_CNT_EN
  logic [15:0] r_sat_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sat_cnt <= '0;
    end else if (w_start_acc) begin
      r_sat_cnt <= '0;
    end else if (w_accept && w_sat && (r_sat_cnt != 16'hFFFF)) begin
      r_sat_cnt <= r_sat_cnt + 16'd1;
    end
  end

  assign sat_cnt = r_sat_cnt;
`else
  logic w_unused_sat;
  assign w_unused_sat = w_sat;
`endif

endmodule
`default_nettype wire

// File: tb/tb_exp_acc_scheduler.sv
`default_nettype none
// ============================================================================
// Module : tb_exp_acc_scheduler
// Brief  : Randomized scoreboard bench for exp_acc_scheduler.
// Rev    : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_exp_acc_scheduler;

  localparam int W     = 6;
  localparam int MAXG  = 64;
  localparam int SMAX  = 24;
  localparam int CNT_W = $clog2(MAXG + 1);

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [CNT_W-1:0] num_groups;
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_max_exp;
  logic             align_valid;
  logic             acc_clear;
  logic [W-1:0]     acc_shift;
  logic [W-1:0]     psum_shift;
  logic [W-1:0]     acc_exp;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out_exp;
  logic             busy;
`ifdef EXP_SCHED_SAT_CNT_EN
  logic [15:0]      sat_cnt;
`endif

  exp_acc_scheduler #(
    .ACC_EXP_WIDTH (W),
    .MAX_GROUPS    (MAXG),
    .SHIFT_MAX     (SMAX)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .num_groups  (num_groups),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_max_exp  (in_max_exp),
    .align_valid (align_valid),
    .acc_clear   (acc_clear),
    .acc_shift   (acc_shift),
    .psum_shift  (psum_shift),
    .acc_exp     (acc_exp),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_exp     (out_exp),
    .busy        (busy)
`ifdef EXP_SCHED_SAT_CNT_EN
    ,
    .sat_cnt     (sat_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int clear;
    int ash;
    int psh;
    int aexp;
  } align_t;

  typedef struct {
    int oexp;
    int sat;
  } res_t;

  align_t align_q[$];
  res_t   res_q[$];
  int     checks   = 0;
  int     failures = 0;
  int     m_acc    = 0;
  int     m_sat    = 0;
  int     n_pulses = 0;
  int     n_beats  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s", name);
  endtask

  // Reference: the accumulator exponent is the max seen so far; the side
  // with the smaller exponent is shifted right by the gap, capped at SMAX.
  function automatic void model_beat(input int e, input bit first);
    align_t x;
    int     gap;
    x.clear = first ? 1 : 0;
    x.ash   = 0;
    x.psh   = 0;
    if (first) begin
      m_acc = e;
    end else begin
      gap = (e > m_acc) ? e - m_acc : m_acc - e;
      if (gap > SMAX && m_sat < 65535) m_sat++;
      if (e > m_acc) begin
        x.ash = (gap > SMAX) ? SMAX : gap;
        m_acc = e;
      end else begin
        x.psh = (gap > SMAX) ? SMAX : gap;
      end
    end
    x.aexp = m_acc;
    align_q.push_back(x);
    n_beats++;
  endfunction

  always begin
    align_t a;
    res_t   r;
    @(negedge clk);
    #2;
    if (align_valid === 1'b1) begin
      n_pulses++;
      if (align_q.size() == 0) begin
        fail_now("align_unexpected_pulse");
      end else begin
        a = align_q.pop_front();
        check("acc_clear",  {31'd0, acc_clear}, a.clear);
        check("acc_shift",  {26'd0, acc_shift}, a.ash);
        check("psum_shift", {26'd0, psum_shift}, a.psh);
        check("acc_exp",    {26'd0, acc_exp}, a.aexp);
      end
    end
    if (out_valid === 1'b1) begin
      check("in_ready_while_out_valid", {31'd0, in_ready}, 0);
      if (res_q.size() == 0) begin
        fail_now("out_valid_unexpected");
      end else begin
        check("out_exp", {26'd0, out_exp}, res_q[0].oexp);
        if (out_ready === 1'b1) begin
          r = res_q.pop_front();
`ifdef EXP_SCHED_SAT_CNT_EN
          check("sat_cnt", {16'd0, sat_cnt}, r.sat);
`endif
        end
      end
    end
  end

  task automatic run_job(input int ng, input int exps[$], input int bubble_pct, input int bp);
    int n;
    int sent;
    int guard;
    n     = (ng == 0) ? 1 : ng;
    sent  = 0;
    guard = 0;
    while (busy && guard < 300) begin
      guard++;
      @(negedge clk);
    end
    if (busy) fail_now("idle_before_start_timeout");
    start      = 1'b1;
    num_groups = CNT_W'(ng);
    m_sat      = 0;
    @(negedge clk);
    start = 1'b0;
    guard = 0;
    while (sent < n && guard < 2000) begin
      if ($urandom_range(99) < bubble_pct) begin
        in_valid = 1'b0;
      end else begin
        in_valid   = 1'b1;
        in_max_exp = W'(exps[sent]);
        if (in_ready) begin
          model_beat(exps[sent], sent == 0);
          sent++;
        end
      end
      // start in RUN must be ignored, whatever num_groups says
      start      = ($urandom_range(3) == 0);
      num_groups = CNT_W'($urandom_range(MAXG));
      out_ready  = $urandom_range(1);
      guard++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    start    = 1'b0;
    if (sent < n) begin
      fail_now("beat_accept_timeout");
    end else begin
      res_q.push_back('{m_acc, m_sat});
    end
    if (bp > 0) begin
      out_ready = 1'b0;
      repeat (bp) begin
        start      = 1'b1;
        num_groups = CNT_W'($urandom_range(1, MAXG));
        @(negedge clk);
      end
      start = 1'b0;
    end
    out_ready = 1'b1;
    guard     = 0;
    while (busy && guard < 300) begin
      guard++;
      @(negedge clk);
    end
    if (busy) fail_now("job_done_timeout");
    check("result_consumed", res_q.size(), 0);
    out_ready = $urandom_range(1);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_in_ready"},    {31'd0, in_ready}, 0);
    check({tag, "_align_valid"}, {31'd0, align_valid}, 0);
    check({tag, "_acc_clear"},   {31'd0, acc_clear}, 0);
    check({tag, "_acc_shift"},   {26'd0, acc_shift}, 0);
    check({tag, "_psum_shift"},  {26'd0, psum_shift}, 0);
    check({tag, "_acc_exp"},     {26'd0, acc_exp}, 0);
    check({tag, "_out_valid"},   {31'd0, out_valid}, 0);
    check({tag, "_out_exp"},     {26'd0, out_exp}, 0);
    check({tag, "_busy"},        {31'd0, busy}, 0);
`ifdef EXP_SCHED_SAT_CNT_EN
    check({tag, "_sat_cnt"},     {16'd0, sat_cnt}, 0);
`endif
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int q[$];
    int n;
    reset      = 1'b1;
    start      = 1'b0;
    num_groups = '0;
    in_valid   = 1'b0;
    in_max_exp = '0;
    out_ready  = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_state("reset");
    reset = 1'b0;
    @(negedge clk);

    q = '{20};                  run_job(1, q, 0, 0);
    q = '{10, 15, 15};          run_job(3, q, 0, 0);
    q = '{40, 5};               run_job(2, q, 0, 0);
    q = '{33, 60, 2};           run_job(3, q, 0, 5);
    q = '{12, 50};              run_job(2, q, 50, 1);
    q = '{7};                   run_job(0, q, 0, 0);
    q = '{0, 63, 63, 0};        run_job(4, q, 20, 2);

    // Abort a job after two of four beats.
    start      = 1'b1;
    num_groups = CNT_W'(4);
    @(negedge clk);
    start = 1'b0;
    q = '{30, 45};
    for (int i = 0; i < 2; i++) begin
      in_valid   = 1'b1;
      in_max_exp = W'(q[i]);
      model_beat(q[i], i == 0);
      @(negedge clk);
    end
    in_valid = 1'b0;
    reset    = 1'b1;
    @(negedge clk);
    #3;
    check_reset_state("midrun_reset");
    reset = 1'b0;
    align_q.delete();
    @(negedge clk);
    q = '{9, 3, 27, 1};         run_job(4, q, 10, 0);

    q.delete();
    for (int i = 0; i < MAXG; i++) q.push_back($urandom_range(63));
    run_job(MAXG, q, 15, 1);

    for (int j = 0; j < 30; j++) begin
      n = $urandom_range(0, 8);
      q.delete();
      for (int i = 0; i < ((n == 0) ? 1 : n); i++) q.push_back($urandom_range(63));
      run_job(n, q, $urandom_range(40), $urandom_range(4));
    end

    repeat (3) @(negedge clk);
    check("align_pulse_total", n_pulses, n_beats);
    check("align_queue_drained", align_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
